// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: active-low csn/wen request plus a
// one-cycle rdy completion strobe with registered read data.
interface mem_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] w;
    logic                  csn;
    logic                  wen;
    logic [DATA_WIDTH-1:0] r;
    logic                  rdy;

    modport master (
        output address, w, csn, wen,
        input  r, rdy
    );

    modport slave (
        input  address, w, csn, wen,
        output r, rdy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between the
// instruction and data requesters; one access in flight, fully registered outputs.
module mem_arbiter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_arbiter_if.slave          inst,
    mem_arbiter_if.slave          data,
    output logic [DATA_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_w,
    output logic                  mem_csn,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_r,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {GNT_INST, GNT_DATA} grant_t;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_t     state;
    grant_t     grant;
    grant_t     last_grant;
    grant_t     pick;
    logic [3:0] count;

    // On a tie the requester not served last wins.
    always_comb begin
        pick = GNT_INST;
        if (!inst.csn && !data.csn)
            pick = (last_grant == GNT_INST) ? GNT_DATA : GNT_INST;
        else if (!data.csn)
            pick = GNT_DATA;
    end

    // The mem_* registers double as the request latches; they hold outside ISSUE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            grant       <= GNT_INST;
            last_grant  <= GNT_INST;
            count       <= '0;
            mem_address <= '0;
            mem_w       <= '0;
            mem_csn     <= 1'b1;
            mem_wen     <= 1'b1;
            inst.r      <= '0;
            data.r      <= '0;
            inst.rdy    <= 1'b0;
            data.rdy    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!inst.csn || !data.csn) begin
                        grant   <= pick;
                        state   <= ISSUE;
                        busy    <= 1'b1;
                        mem_csn <= 1'b0;
                        if (pick == GNT_DATA) begin
                            mem_address <= data.address;
                            mem_w       <= data.w;
                            mem_wen     <= data.wen;
                        end else begin
                            mem_address <= inst.address;
                            mem_w       <= inst.w;
                            mem_wen     <= inst.wen;
                        end
                    end
                end
                ISSUE: begin
                    mem_csn <= 1'b1;
                    mem_wen <= 1'b1;
                    count   <= CNT_LOAD;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (count == '0) begin
                        if (grant == GNT_DATA) begin
                            data.r   <= mem_r;
                            data.rdy <= 1'b1;
                        end else begin
                            inst.r   <= mem_r;
                            inst.rdy <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    inst.rdy   <= 1'b0;
                    data.rdy   <= 1'b0;
                    last_grant <= grant;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two instances (latency 1 and 3) with
// behavioural SRAM models and a scoreboard of expected rdy completions.
module tb_mem_arbiter;
    localparam int unsigned DW = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cyc = '0;
    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    mem_arbiter_if #(.DATA_WIDTH(DW)) inst1 ();
    mem_arbiter_if #(.DATA_WIDTH(DW)) data1 ();
    mem_arbiter_if #(.DATA_WIDTH(DW)) inst3 ();
    mem_arbiter_if #(.DATA_WIDTH(DW)) data3 ();

    logic [31:0] m1_address, m1_w, m1_r, m3_address, m3_w, m3_r;
    logic        m1_csn, m1_wen, busy1, m3_csn, m3_wen, busy3;

    mem_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .inst(inst1), .data(data1),
        .mem_address(m1_address), .mem_w(m1_w), .mem_csn(m1_csn),
        .mem_wen(m1_wen), .mem_r(m1_r), .busy(busy1)
    );

    mem_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .inst(inst3), .data(data3),
        .mem_address(m3_address), .mem_w(m3_w), .mem_csn(m3_csn),
        .mem_wen(m3_wen), .mem_r(m3_r), .busy(busy3)
    );

    // SRAM models: read data is valid only in the L-th cycle after the select
    // cycle and is garbage otherwise, so a mistimed capture shows up.
    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [15:0] rv1 = '0;
    logic [15:0] rv3 = '0;
    logic [31:0] rd1 [16];
    logic [31:0] rd3 [16];

    always @(posedge clk) begin
        if (cyc == 32'd0) begin
            mem1[8'h10] <= 32'hDEADBEEF;
            mem1[8'h20] <= 32'h00000000;
            mem1[8'h40] <= 32'h40404040;
            mem1[8'h44] <= 32'h44444444;
        end else if (!m1_csn && !m1_wen) begin
            mem1[m1_address[7:0]] <= m1_w;
        end
        rv1    <= {rv1[14:0], (!m1_csn && m1_wen)};
        rd1[0] <= mem1[m1_address[7:0]];
        for (int i = 15; i > 0; i--) rd1[i] <= rd1[i-1];
    end

    always @(posedge clk) begin
        if (cyc == 32'd0) begin
            mem3[8'h04] <= 32'hCAFEF00D;
            mem3[8'h08] <= 32'h0BADF00D;
        end else if (!m3_csn && !m3_wen) begin
            mem3[m3_address[7:0]] <= m3_w;
        end
        rv3    <= {rv3[14:0], (!m3_csn && m3_wen)};
        rd3[0] <= mem3[m3_address[7:0]];
        for (int i = 15; i > 0; i--) rd3[i] <= rd3[i-1];
    end

    assign m1_r = rv1[0] ? rd1[0] : (32'hBAD00000 | cyc);
    assign m3_r = rv3[2] ? rd3[2] : (32'hBAD00000 | cyc);

    typedef struct {
        bit          is_data;
        bit          is_read;
        logic [31:0] rdata;
        logic [31:0] at;
        string       tag;
    } exp_t;

    exp_t sbq [2][$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_rdy(int unsigned d, bit is_data, bit is_read,
                              logic [31:0] rdata, logic [31:0] at, string tag);
        exp_t e;
        e.is_data = is_data;
        e.is_read = is_read;
        e.rdata   = rdata;
        e.at      = at;
        e.tag     = tag;
        sbq[d].push_back(e);
    endtask

    task automatic mon(int unsigned d, logic irdy, logic drdy,
                       logic [31:0] ir, logic [31:0] dr);
        exp_t e;
        if (irdy || drdy) begin
            if (sbq[d].size() == 0) begin
                check($sformatf("dut%0d_unexpected_rdy", d), {30'b0, drdy, irdy}, 32'h0);
            end else begin
                e = sbq[d].pop_front();
                check({e.tag, "_rdy"}, {30'b0, drdy, irdy}, e.is_data ? 32'h2 : 32'h1);
                check({e.tag, "_cycle"}, cyc, e.at);
                if (e.is_read) check({e.tag, "_rdata"}, e.is_data ? dr : ir, e.rdata);
            end
        end
    endtask

    always @(negedge clk) mon(0, inst1.rdy, data1.rdy, inst1.r, data1.r);
    always @(negedge clk) mon(1, inst3.rdy, data3.rdy, inst3.r, data3.r);

    task automatic tick(int unsigned k);
        repeat (k) @(negedge clk);
    endtask

    logic [31:0] n;

    initial begin
        inst1.csn = 1'b1; inst1.wen = 1'b1; inst1.address = '0; inst1.w = '0;
        data1.csn = 1'b1; data1.wen = 1'b1; data1.address = '0; data1.w = '0;
        inst3.csn = 1'b1; inst3.wen = 1'b1; inst3.address = '0; inst3.w = '0;
        data3.csn = 1'b1; data3.wen = 1'b1; data3.address = '0; data3.w = '0;

        // Reset held with both sides requesting.
        inst1.address = 32'h44; inst1.csn = 1'b0;
        data1.address = 32'h40; data1.csn = 1'b0;
        tick(3);
        check("rst_mem_csn", {31'b0, m1_csn}, 32'h1);
        check("rst_mem_wen", {31'b0, m1_wen}, 32'h1);
        check("rst_mem_address", m1_address, 32'h0);
        check("rst_mem_w", m1_w, 32'h0);
        check("rst_busy", {31'b0, busy1}, 32'h0);
        check("rst_rdy", {30'b0, data1.rdy, inst1.rdy}, 32'h0);
        check("rst_inst_r", inst1.r, 32'h0);
        check("rst_data_r", data1.r, 32'h0);
        check("rst_busy3", {31'b0, busy3}, 32'h0);

        // Contention from release: data, inst, data, inst, 4 cycles apart.
        rst = 1'b1;
        n = cyc;
        expect_rdy(0, 1, 1, 32'h40404040, n + 3,  "cont_data0");
        expect_rdy(0, 0, 1, 32'h44444444, n + 7,  "cont_inst0");
        expect_rdy(0, 1, 1, 32'h40404040, n + 11, "cont_data1");
        expect_rdy(0, 0, 1, 32'h44444444, n + 15, "cont_inst1");
        tick(1);
        check("cont_first_csn", {31'b0, m1_csn}, 32'h0);
        check("cont_first_addr", m1_address, 32'h40);
        check("cont_first_busy", {31'b0, busy1}, 32'h1);
        tick(14);
        inst1.csn = 1'b1;
        data1.csn = 1'b1;
        tick(2);
        check("cont_idle_busy", {31'b0, busy1}, 32'h0);
        check("cont_idle_csn", {31'b0, m1_csn}, 32'h1);

        // Single read on the instruction side.
        inst1.address = 32'h10; inst1.wen = 1'b1; inst1.csn = 1'b0;
        n = cyc;
        expect_rdy(0, 0, 1, 32'hDEADBEEF, n + 3, "rd_inst");
        tick(1);
        check("rd_issue_csn", {31'b0, m1_csn}, 32'h0);
        check("rd_issue_addr", m1_address, 32'h10);
        check("rd_issue_wen", {31'b0, m1_wen}, 32'h1);
        tick(1);
        check("rd_wait_csn", {31'b0, m1_csn}, 32'h1);
        check("rd_wait_busy", {31'b0, busy1}, 32'h1);
        tick(1);
        inst1.csn = 1'b1;
        tick(1);

        // Single write on the data side.
        data1.address = 32'h20; data1.w = 32'h12345678; data1.wen = 1'b0; data1.csn = 1'b0;
        n = cyc;
        expect_rdy(0, 1, 0, 32'h0, n + 3, "wr_data");
        tick(1);
        check("wr_issue_csn", {31'b0, m1_csn}, 32'h0);
        check("wr_issue_wen", {31'b0, m1_wen}, 32'h0);
        check("wr_issue_w", m1_w, 32'h12345678);
        check("wr_issue_addr", m1_address, 32'h20);
        tick(1);
        check("wr_wait_wen", {31'b0, m1_wen}, 32'h1);
        check("wr_wait_w_hold", m1_w, 32'h12345678);
        tick(1);
        data1.csn = 1'b1; data1.wen = 1'b1;
        check("wr_inst_r_hold", inst1.r, 32'hDEADBEEF);
        tick(1);

        // Read back the written word through the other requester.
        inst1.address = 32'h20; inst1.csn = 1'b0;
        n = cyc;
        expect_rdy(0, 0, 1, 32'h12345678, n + 3, "rdback_inst");
        tick(3);
        inst1.csn = 1'b1;
        tick(1);

        // Latency 3: capture must land on the single valid cycle.
        inst3.address = 32'h4; inst3.csn = 1'b0;
        n = cyc;
        expect_rdy(1, 0, 1, 32'hCAFEF00D, n + 5, "lat3_inst");
        tick(1);
        check("lat3_issue_csn", {31'b0, m3_csn}, 32'h0);
        check("lat3_issue_addr", m3_address, 32'h4);
        tick(1);
        check("lat3_wait_csn", {31'b0, m3_csn}, 32'h1);
        check("lat3_wait_busy", {31'b0, busy3}, 32'h1);
        tick(3);
        inst3.csn = 1'b1;
        tick(1);

        // Reset in the middle of WAIT abandons the access with no rdy.
        data3.address = 32'h8; data3.csn = 1'b0;
        tick(3);
        check("midrst_pre_busy", {31'b0, busy3}, 32'h1);
        rst = 1'b0;
        data3.csn = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy3}, 32'h0);
        check("midrst_csn", {31'b0, m3_csn}, 32'h1);
        check("midrst_rdy", {30'b0, data3.rdy, inst3.rdy}, 32'h0);
        check("midrst_inst_r", inst3.r, 32'h0);
        tick(2);
        rst = 1'b1;
        tick(3);
        check("midrst_idle_busy", {31'b0, busy3}, 32'h0);

        data3.csn = 1'b0;
        n = cyc;
        expect_rdy(1, 1, 1, 32'h0BADF00D, n + 5, "postrst_data");
        tick(5);
        data3.csn = 1'b1;
        tick(2);

        check("sb1_drained", sbq[0].size(), 32'h0);
        check("sb3_drained", sbq[1].size(), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-port synchronous SRAM between the core's instruction bus and data bus. Sits between `core` and the unified program/data memory; each core-side bus keeps its active-low `csn`/`wen` protocol, and the arbiter adds a `rdy` strobe per requester. Grants are round-robin on contention, one access in flight at a time, with configurable memory read latency.

## Interface
- DATA_WIDTH, 32, width of address and data buses
- MEM_LATENCY, 1, cycles from `mem_csn` low to `mem_rdata` valid; legal range 1..15
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- inst_address  in  DATA_WIDTH  instruction requester address
- inst_w  in  DATA_WIDTH  instruction write data
- inst_csn  in  1  instruction request, active-low
- inst_wen  in  1  instruction write enable, active-low (0 = write)
- inst_r  out  DATA_WIDTH  instruction read data, valid while `inst_rdy`=1
- inst_rdy  out  1  one-cycle completion strobe, instruction side
- data_address, data_w, data_csn, data_wen, data_r, data_rdy: same as above, data side
- mem_address  out  DATA_WIDTH  shared memory address
- mem_w  out  DATA_WIDTH  shared memory write data
- mem_csn  out  1  shared memory chip select, active-low
- mem_wen  out  1  shared memory write enable, active-low
- mem_r  in  DATA_WIDTH  shared memory read data
- busy  out  1  high in any state other than IDLE

## Operation
- FSM: IDLE, ISSUE, WAIT, RESP.
- IDLE: sample both `*_csn`. None low -> stay. One low -> grant it. Both low -> grant the requester not granted last; `last_grant` resets to INST, so data wins the first tie. On grant, latch address, write data, `wen` and grant ID; go ISSUE.
- ISSUE (1 cycle): `mem_csn`=0, `mem_wen`=latched wen, `mem_address`/`mem_w` = latched values. Load latency counter with MEM_LATENCY-1. Go WAIT.
- WAIT: `mem_csn`=1, `mem_wen`=1. Counter 0 -> capture `mem_r` into the granted requester's read register, go RESP; otherwise decrement. For MEM_LATENCY=1, WAIT lasts exactly one cycle.
- RESP (1 cycle): granted `*_rdy`=1; the other `*_rdy`=0. Update `last_grant` to the served ID. Go IDLE.
- Writes follow the same path and timing; the read register is still updated with `mem_r` and its content is don't-care.
- Requesters hold `csn`, `wen`, address and write data stable from assertion through the `rdy` cycle inclusive. Requests are not sampled in ISSUE, WAIT or RESP; changes there are ignored. A `csn` still low in the IDLE cycle after RESP is a new request.
- `inst_r` and `data_r` are registered and hold their last captured value until the next capture for that side.
- `mem_address` and `mem_w` hold their last values outside ISSUE.

## Timing
- Reset values (async, take effect immediately on `rst`=0): state IDLE, `mem_csn`=1, `mem_wen`=1, `mem_address`=0, `mem_w`=0, `inst_rdy`=`data_rdy`=0, `inst_r`=`data_r`=0, `busy`=0, `last_grant`=INST.
- Reset mid-access: the in-flight access is abandoned and no `rdy` is issued. Requesters must re-request after reset release.
- All outputs are registered; there is no combinational path from any input to any output.
- Latency: request seen in IDLE at cycle T -> `mem_csn` low at T+1 -> `rdy` at T+2+MEM_LATENCY. Per-access occupancy is 3+MEM_LATENCY cycles (4 at the default).
- Back-to-back throughput with both sides requesting continuously: alternating grants, one completion per 3+MEM_LATENCY cycles, and neither side waits more than one foreign access.
- `busy`=1 from T+1 through the RESP cycle.

## Test plan
- Reset: hold `rst`=0 with `data_csn`=0 -> `mem_csn`=1, `busy`=0, both `rdy`=0. Release and keep requesting -> `mem_csn`=0 two cycles after release edge sampling.
- Single read: `inst_csn`=0, `inst_wen`=1, `inst_address`=0x10, memory returns 0xDEADBEEF -> `mem_csn` low 1 cycle with `mem_address`=0x10; `inst_rdy`=1 and `inst_r`=0xDEADBEEF exactly 3 cycles after the sample cycle (MEM_LATENCY=1).
- Single write: `data_csn`=0, `data_wen`=0, addr 0x20, data 0x12345678 -> one ISSUE cycle with `mem_csn`=0, `mem_wen`=0, `mem_w`=0x12345678; then `data_rdy`=1; `inst_rdy` stays 0.
- Contention: both `csn` low from reset release -> order of `rdy` strobes is data, inst, data, inst; each completion 4 cycles apart.
- Latency sweep: MEM_LATENCY=3, read addr 0x4 -> `rdy` at T+5; `mem_r` is captured at the correct cycle, verified with memory model returning garbage before valid.
- Reset mid-WAIT: assert `rst`=0 during WAIT -> no `rdy` pulse, `busy` drops immediately, next request after release completes normally.
